mul_share_ctrl: RTL

Shared-multiplier controller for the 8x8 multiply subsystem. It arbitrates between two requesters and grants one at a time, round-robin on ties. It then runs an internal 8-iteration unsigned shift-add multiply on the granted operands and returns the 16-bit product with a one-cycle valid strobe to the winning requester. It replaces ad-hoc done/enable sequencing around the product register with a single req/gnt/vld handshake.

---
 rtl/mul_share_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mul_share_ctrl.sv
// Shared 8x8 shift-add multiplier with two-requester round-robin arbitration.
// One req/gnt/vld handshake per operation; result returned on a registered shared bus.
module mul_share_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               vld0,
  output logic               vld1,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   mcand, mcand_n;
  logic [WIDTH-1:0]   mplier, mplier_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [2*WIDTH-1:0] prod_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               owner, owner_n;
  logic               last, last_n;
  logic               gnt0_n, gnt1_n, vld0_n, vld1_n;
  logic [WIDTH:0]     sum;
  logic               pick1;

  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    prod_n   = prod;
    cnt_n    = cnt;
    owner_n  = owner;
    last_n   = last;
    gnt0_n   = 1'b0;
    gnt1_n   = 1'b0;
    vld0_n   = 1'b0;
    vld1_n   = 1'b0;
    // Upper half plus carry; the carry becomes the new MSB after the shift.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    // Requester 1 wins if alone, or on a tie when requester 0 was served last.
    pick1    = req1 && (!req0 || (last == 1'b0));

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          mcand_n  = pick1 ? a1 : a0;
          mplier_n = pick1 ? b1 : b0;
          acc_n    = '0;
          cnt_n    = '0;
          owner_n  = pick1;
          last_n   = pick1;
          gnt0_n   = !pick1;
          gnt1_n   = pick1;
          state_n  = RUN;
        end
      end
      RUN: begin
        acc_n    = {sum, acc[WIDTH-1:1]};
        mplier_n = mplier >> 1;
        cnt_n    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          prod_n  = {sum, acc[WIDTH-1:1]};
          vld0_n  = !owner;
          vld1_n  = owner;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      prod   <= '0;
      cnt    <= '0;
      owner  <= 1'b0;
      last   <= 1'b1;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      vld0   <= 1'b0;
      vld1   <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      prod   <= prod_n;
      cnt    <= cnt_n;
      owner  <= owner_n;
      last   <= last_n;
      gnt0   <= gnt0_n;
      gnt1   <= gnt1_n;
      vld0   <= vld0_n;
      vld1   <= vld1_n;
    end
  end

endmodule
